alu_booth_ctrl: RTL

//  Sequencer that drives the shared combinational add/sub ALU to do signed
//  N_BITS x N_BITS -> 2*N_BITS multiplication (radix-2 Booth), one step/clock.

---
 rtl/alu_booth_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_booth_ctrl.sv
// Radix-2 Booth sequencer driving an external add/sub ALU: signed N_BITS x N_BITS -> 2*N_BITS.
// Optional build macro MUL_ZERO_SKIP_EN: a zero operand jumps straight to DONE with a zero product.
module alu_booth_ctrl #(
    parameter int N_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_BITS-1:0]     in_a,
    input  logic [N_BITS-1:0]     in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*N_BITS-1:0]   out_prod,
    output logic [N_BITS-1:0]     o_alu_a,
    output logic [N_BITS-1:0]     o_alu_b,
    output logic                  o_alu_op,
    input  logic [N_BITS-1:0]     i_alu_res
);

    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q;
    logic [N_BITS-1:0]     acc_q;
    logic [N_BITS-1:0]     mulQ_q;
    logic                  qMinus1_q;
    logic [N_BITS-1:0]     mcand_q;
    logic [CW-1:0]         count_q;
    logic                  inReady_q;
    logic                  outValid_q;
    logic [2*N_BITS-1:0]   outProd_q;
    logic [N_BITS-1:0]     aluA_q;
    logic [N_BITS-1:0]     aluB_q;
    logic                  aluOp_q;

    logic                  ovf;
    logic                  trueSign;
    logic [N_BITS-1:0]     acc_d;
    logic [N_BITS-1:0]     mulQ_d;
    logic                  zeroSkip;

    // Booth pair {Q0, q_1} -> {op, b}: 10 subtracts M, 01 adds M, else adds zero.
    function automatic logic [N_BITS:0] boothSel(input logic [1:0] pair, input logic [N_BITS-1:0] m);
        case (pair)
            2'b10:   boothSel = {1'b0, m};
            2'b01:   boothSel = {1'b1, m};
            default: boothSel = {1'b1, {N_BITS{1'b0}}};
        endcase
    endfunction

`ifdef MUL_ZERO_SKIP_EN
    assign zeroSkip = (in_a == '0) || (in_b == '0);
`else
    assign zeroSkip = 1'b0;
`endif

    // The ALU result is only N bits wide; the overflow flag recovers the sign bit of the
    // true N+1-bit sum so the arithmetic shift stays exact, including for -2^(N-1) operands.
    always_comb begin
        ovf = 1'b0;
        if (aluOp_q)
            ovf = (aluA_q[N_BITS-1] == aluB_q[N_BITS-1]) && (i_alu_res[N_BITS-1] != aluA_q[N_BITS-1]);
        else
            ovf = (aluA_q[N_BITS-1] != aluB_q[N_BITS-1]) && (i_alu_res[N_BITS-1] != aluA_q[N_BITS-1]);
        trueSign = i_alu_res[N_BITS-1] ^ ovf;
        acc_d    = {trueSign, i_alu_res[N_BITS-1:1]};
        mulQ_d   = {i_alu_res[0], mulQ_q[N_BITS-1:1]};
    end

    // After the shift the next Booth pair is {Q[1], Q[0]}, so ALU ports can be registered a step ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mulQ_q     <= '0;
            qMinus1_q  <= 1'b0;
            mcand_q    <= '0;
            count_q    <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            outProd_q  <= '0;
            aluA_q     <= '0;
            aluB_q     <= '0;
            aluOp_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q   <= in_a;
                        acc_q     <= '0;
                        qMinus1_q <= 1'b0;
                        count_q   <= '0;
                        inReady_q <= 1'b0;
                        if (zeroSkip) begin
                            mulQ_q     <= '0;
                            outProd_q  <= '0;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            mulQ_q             <= in_b;
                            aluA_q             <= '0;
                            {aluOp_q, aluB_q}  <= boothSel({in_b[0], 1'b0}, in_a);
                            state_q            <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q     <= acc_d;
                    mulQ_q    <= mulQ_d;
                    qMinus1_q <= mulQ_q[0];
                    count_q   <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q    <= DONE;
                        outValid_q <= 1'b1;
                        outProd_q  <= {acc_d, mulQ_d};
                        aluA_q     <= '0;
                        aluB_q     <= '0;
                        aluOp_q    <= 1'b1;
                    end else begin
                        aluA_q            <= acc_d;
                        {aluOp_q, aluB_q} <= boothSel(mulQ_q[1:0], mcand_q);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    aluA_q     <= '0;
                    aluB_q     <= '0;
                    aluOp_q    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_prod  = outProd_q;
    assign o_alu_a   = aluA_q;
    assign o_alu_b   = aluB_q;
    assign o_alu_op  = aluOp_q;

endmodule
